// File: rtl/mult_control_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: state encoding and default sizing.
package mult_control_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_TEST  = 3'd2,
      ST_ADD   = 3'd3,
      ST_SHIFT = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer; flags the final iteration.
module mult_iter_counter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count,
   output logic             o_last
);

   logic [CNT_W-1:0] r_count;

   // clr outranks inc so an abort or reload always lands on zero
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr)
         r_count <= '0;
      else if (i_inc)
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;
   assign o_last  = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Sequencer for the shift-add multiplier datapath: strobes load/add/shift and handshakes start/busy/done.
//
//  state | meaning
//  IDLE  | waiting for start
//  LOAD  | datapath loads operands, product high half cleared
//  TEST  | inspect multiplier LSB
//  ADD   | product_hi += multiplicand
//  SHIFT | shift product/multiplier right, advance iteration
//  DONE  | one-cycle done pulse, product valid
module mult_control
   import mult_control_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_mplier_lsb,
   output logic             o_load,
   output logic             o_add_en,
   output logic             o_shift_en,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_iter_count
);

   state_t r_state;
   state_t w_state_nxt;
   logic   w_abort_act;
   logic   w_cnt_clr;
   logic   w_cnt_inc;
   logic   w_last;

   assign w_abort_act = i_abort && (r_state != ST_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_state_nxt = ST_LOAD;
         ST_LOAD:  w_state_nxt = ST_TEST;
         ST_TEST:  w_state_nxt = i_mplier_lsb ? ST_ADD : ST_SHIFT;
         ST_ADD:   w_state_nxt = ST_SHIFT;
         ST_SHIFT: w_state_nxt = w_last ? ST_DONE : ST_TEST;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
      if (w_abort_act)
         w_state_nxt = ST_IDLE;
   end

   // Count holds at WIDTH-1 through DONE/IDLE; only LOAD or abort return it to zero
   assign w_cnt_clr = (r_state == ST_LOAD) || w_abort_act;
   assign w_cnt_inc = (r_state == ST_SHIFT) && !w_last;

   mult_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_cnt_clr),
      .i_inc   (w_cnt_inc),
      .o_count (o_iter_count),
      .o_last  (w_last)
   );

   assign o_load     = (r_state == ST_LOAD);
   assign o_add_en   = (r_state == ST_ADD);
   assign o_shift_en = (r_state == ST_SHIFT);
   assign o_done     = (r_state == ST_DONE);
   assign o_busy     = (r_state != ST_IDLE);

endmodule
